// File: rtl/tri_dispatcher.sv
// Triangle dispatcher: buffers incoming triangles in a small FIFO and issues
// them one at a time to a rasterizer, tracking per-frame triangle counts.
module tri_dispatcher #(
    parameter int XWIDTH    = 16,
    parameter int YWIDTH    = 16,
    parameter int ZWIDTH    = 16,
    parameter int N         = 3,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   tri_valid_in,
    output logic                   tri_ready_out,
    input  logic [N*XWIDTH-1:0]    x_in,
    input  logic [N*YWIDTH-1:0]    y_in,
    input  logic [N*ZWIDTH-1:0]    z_in,
    input  logic                   tri_last_in,
    input  logic                   rast_ready_in,
    output logic                   rast_valid_out,
    output logic [N*XWIDTH-1:0]    rast_x_out,
    output logic [N*YWIDTH-1:0]    rast_y_out,
    output logic [N*ZWIDTH-1:0]    rast_z_out,
    output logic                   busy_out,
    output logic                   frame_done_out,
    output logic [CNT_WIDTH-1:0]   tri_count_out,
    output logic [CNT_WIDTH-1:0]   frame_tri_count_out
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int XW = N * XWIDTH;
    localparam int YW = N * YWIDTH;
    localparam int ZW = N * ZWIDTH;
    localparam int EW = XW + YW + ZW + 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t state_reg, state_next;

    logic [EW-1:0]        mem [DEPTH];
    logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]          count_reg;
    logic                 pending_last_reg;
    logic                 frame_done_reg;
    logic [CNT_WIDTH-1:0] tri_count_reg, frame_tri_count_reg;
    logic [XW-1:0]        rast_x_reg;
    logic [YW-1:0]        rast_y_reg;
    logic [ZW-1:0]        rast_z_reg;
    logic [EW-1:0]        head;

    logic push, pop, frame_end;

    // Ready comes from the registered occupancy only, so a full FIFO never
    // accepts even when the head is popped in the same cycle.
    assign tri_ready_out = (count_reg != FULL_COUNT);
    assign push          = tri_valid_in && tri_ready_out;
    assign frame_end     = (state_reg == WAIT) && rast_ready_in && pending_last_reg;
    assign head          = mem[rd_ptr_reg];

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if ((count_reg != '0) && rast_ready_in) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = WAIT;
            WAIT:    if (rast_ready_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Storage has no reset so it can map onto block RAM; the read is
    // registered through the rast_* output registers below.
    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr_reg] <= {x_in, y_in, z_in, tri_last_in};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rast_x_reg <= '0;
            rast_y_reg <= '0;
            rast_z_reg <= '0;
        end else if (pop) begin
            rast_x_reg <= head[EW-1 -: XW];
            rast_y_reg <= head[EW-1-XW -: YW];
            rast_z_reg <= head[ZW:1];
        end
    end

    // Pop and frame_end are mutually exclusive (IDLE vs WAIT), so the
    // counter never sees both in one cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending_last_reg    <= 1'b0;
            frame_done_reg      <= 1'b0;
            tri_count_reg       <= '0;
            frame_tri_count_reg <= '0;
        end else begin
            frame_done_reg <= frame_end;
            if (pop) begin
                tri_count_reg <= tri_count_reg + CNT_WIDTH'(1);
                if (head[0]) pending_last_reg <= 1'b1;
            end else if (frame_end) begin
                frame_tri_count_reg <= tri_count_reg;
                tri_count_reg       <= '0;
                pending_last_reg    <= 1'b0;
            end
        end
    end

    assign rast_valid_out      = (state_reg == ISSUE);
    assign rast_x_out          = rast_x_reg;
    assign rast_y_out          = rast_y_reg;
    assign rast_z_out          = rast_z_reg;
    assign busy_out            = (count_reg != '0) || (state_reg != IDLE);
    assign frame_done_out      = frame_done_reg;
    assign tri_count_out       = tri_count_reg;
    assign frame_tri_count_out = frame_tri_count_reg;

endmodule
